// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, field positions and FSM states shared by the
// 2-way write-through data cache and its per-way storage.
package dcache_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int TAG_W     = 6;
  localparam int SET_W     = 6;
  localparam int WORD_W    = 3;
  localparam int NUM_SETS  = 64;
  localparam int NUM_WAYS  = 2;
  localparam int NUM_WORDS = 8;
  localparam int TAG_LSB   = 10;
  localparam int SET_LSB   = 4;
  localparam int WORD_LSB  = 1;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [SET_W-1:0]  set_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic set_t addr_set(input logic [ADDR_W-1:0] a);
    return a[SET_LSB +: SET_W];
  endfunction

  function automatic word_t addr_word(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// dcache_way_store: one way's tag, valid and data arrays.
// Combinational read; synchronous word and tag writes; async valid clear.
module dcache_way_store
  import dcache_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  set_t  rd_set,
  input  word_t rd_word,
  output tag_t  rd_tag,
  output logic  rd_valid,
  output data_t rd_data,
  input  logic  word_we,
  input  set_t  word_set,
  input  word_t word_idx,
  input  data_t word_data,
  input  logic  tag_we,
  input  set_t  tag_set,
  input  tag_t  tag_data,
  input  logic  inv_we,
  input  set_t  inv_set
);

  data_t               data_q [NUM_SETS][NUM_WORDS];
  tag_t                tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;

  assign rd_tag   = tag_q[rd_set];
  assign rd_valid = valid_q[rd_set];
  assign rd_data  = data_q[rd_set][rd_word];

  always_ff @(posedge clk) begin
    if (word_we) begin
      data_q[word_set][word_idx] <= word_data;
    end
    if (tag_we) begin
      tag_q[tag_set] <= tag_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inv_we) begin
        valid_q[inv_set] <= 1'b0;
      end
      if (tag_we) begin
        valid_q[tag_set] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: 2-way set-associative write-through/write-allocate
// data cache. `DCACHE_PERF_CNT_EN adds saturating hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        stall,
  output logic        miss_detected,
  output logic [15:0] miss_address,
  input  logic        fill_write_data,
  input  logic        fill_write_tag,
  input  logic [15:0] fill_data,
  input  logic        mem_busy,
  output logic        mem_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  state_t state_q, state_d;
  set_t   fill_set_q;
  tag_t   fill_tag_q;
  logic   fill_way_q;
  word_t  fill_cnt_q;

  logic [NUM_SETS-1:0] lru_q;

  set_t  req_set;
  tag_t  req_tag;
  word_t req_word;

  tag_t          way_tag   [NUM_WAYS];
  data_t         way_data  [NUM_WAYS];
  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_match;
  logic [NUM_WAYS-1:0] word_we;
  logic [NUM_WAYS-1:0] tag_we;
  logic [NUM_WAYS-1:0] inv_we;

  logic  hit_way, victim, in_fill, store_blk, accept;
  logic  start_fill, fill_word, fill_done;
  set_t  wr_set;
  word_t wr_word;
  data_t wr_data;

  assign req_set  = addr_set(req_addr);
  assign req_tag  = addr_tag(req_addr);
  assign req_word = addr_word(req_addr);

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    dcache_way_store u_way (
      .clk       (clk),
      .rst       (rst),
      .rd_set    (req_set),
      .rd_word   (req_word),
      .rd_tag    (way_tag[g]),
      .rd_valid  (way_valid[g]),
      .rd_data   (way_data[g]),
      .word_we   (word_we[g]),
      .word_set  (wr_set),
      .word_idx  (wr_word),
      .word_data (wr_data),
      .tag_we    (tag_we[g]),
      .tag_set   (fill_set_q),
      .tag_data  (fill_tag_q),
      .inv_we    (inv_we[g]),
      .inv_set   (req_set)
    );
    assign way_match[g] = way_valid[g] && (way_tag[g] == req_tag);
    assign tag_we[g]    = fill_done && (fill_way_q == g[0]);
    assign inv_we[g]    = start_fill && (victim == g[0]);
  end

  assign in_fill  = (state_q == FILL);
  assign hit      = req_valid && (|way_match);
  assign hit_way  = ~way_match[0];
  assign rdata    = (hit && !rst) ? way_data[hit_way] : '0;
  assign victim   = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[req_set];

  // A store is also held off in FILL so the write port never fires there.
  assign store_blk     = req_write && (mem_busy || in_fill);
  assign stall         = !rst && req_valid && (!hit || store_blk);
  assign accept        = !rst && hit && !store_blk;
  assign miss_detected = req_valid && !hit && !rst;
  assign miss_address  = {req_addr[15:4], 4'h0};
  assign mem_write_en  = accept && req_write;
  assign mem_addr      = req_addr;
  assign mem_wdata     = req_wdata;

  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    fill_word  = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        fill_word = fill_write_data;
        if (fill_write_tag) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    word_we = '0;
    wr_set  = req_set;
    wr_word = req_word;
    wr_data = req_wdata;
    unique case (1'b1)
      fill_word: begin
        word_we[fill_way_q] = 1'b1;
        wr_set              = fill_set_q;
        wr_word             = fill_cnt_q;
        wr_data             = fill_data;
      end
      mem_write_en: word_we[hit_way] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_set_q <= '0;
      fill_tag_q <= '0;
      fill_way_q <= 1'b0;
      fill_cnt_q <= '0;
      lru_q      <= '0;
    end else begin
      if (start_fill) begin
        fill_set_q <= req_set;
        fill_tag_q <= req_tag;
        fill_way_q <= victim;
      end
      if (fill_done) begin
        fill_cnt_q <= '0;
      end else if (fill_word) begin
        fill_cnt_q <= fill_cnt_q + word_t'(1);
      end
      if (accept) begin
        lru_q[req_set] <= ~hit_way;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (start_fill && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: random and directed stimulus checked against an
// array-level cache model and a flat backing memory.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] rdata;
  logic        hit, stall, miss_detected;
  logic [15:0] miss_address;
  logic        fill_write_data = 1'b0;
  logic        fill_write_tag = 1'b0;
  logic [15:0] fill_data = '0;
  logic        mem_busy = 1'b0;
  logic        mem_write_en;
  logic [15:0] mem_addr, mem_wdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rdata           (rdata),
    .hit             (hit),
    .stall           (stall),
    .miss_detected   (miss_detected),
    .miss_address    (miss_address),
    .fill_write_data (fill_write_data),
    .fill_write_tag  (fill_write_tag),
    .fill_data       (fill_data),
    .mem_busy        (mem_busy),
    .mem_write_en    (mem_write_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // Reference: cache contents as plain arrays plus the word-addressed memory.
  bit          m_valid [64][2];
  logic [5:0]  m_tag   [64][2];
  logic [15:0] m_data  [64][2][8];
  bit          m_lru   [64];
  logic [15:0] mem     [32768];
  bit          m_fill = 0;
  logic [5:0]  m_fset, m_ftag;
  int          m_fway;
  logic [2:0]  m_fcnt = '0;

  function automatic logic [67:0] model_out();
    logic [5:0] s, t;
    logic [2:0] wd;
    logic h, st, md, we;
    logic [15:0] rd;
    int w;
    s = req_addr[9:4];
    t = req_addr[15:10];
    wd = req_addr[3:1];
    h = 1'b0;
    w = 0;
    for (int i = 0; i < 2; i++)
      if (!h && m_valid[s][i] && m_tag[s][i] == t) begin
        h = 1'b1;
        w = i;
      end
    h = h && req_valid && !rst;
    rd = h ? m_data[s][w][wd] : 16'h0;
    md = req_valid && !h && !rst;
    st = !rst && req_valid && (!h || (req_write && mem_busy));
    we = !rst && h && req_write && !mem_busy && !m_fill;
    return {h, rd, st, md, req_addr[15:4], 4'h0, we,
            we ? req_addr : 16'h0, we ? req_wdata : 16'h0};
  endfunction

  function automatic logic [67:0] dut_out();
    return {hit, rdata, stall, miss_detected, miss_address, mem_write_en,
            mem_write_en ? mem_addr : 16'h0,
            mem_write_en ? mem_wdata : 16'h0};
  endfunction

  task automatic model_edge();
    logic [5:0] s, t;
    logic h;
    int w;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i][0] = 0;
        m_valid[i][1] = 0;
        m_lru[i] = 0;
      end
      m_fill = 0;
      m_fcnt = '0;
      return;
    end
    s = req_addr[9:4];
    t = req_addr[15:10];
    h = 1'b0;
    w = 0;
    for (int i = 0; i < 2; i++)
      if (!h && m_valid[s][i] && m_tag[s][i] == t) begin
        h = 1'b1;
        w = i;
      end
    if (m_fill) begin
      if (fill_write_data) begin
        m_data[m_fset][m_fway][m_fcnt] = fill_data;
        m_fcnt = m_fcnt + 3'd1;
      end
      if (fill_write_tag) begin
        m_tag[m_fset][m_fway] = m_ftag;
        m_valid[m_fset][m_fway] = 1;
        m_fcnt = '0;
        m_fill = 0;
      end
    end else if (req_valid && !h) begin
      m_fill = 1;
      m_fset = s;
      m_ftag = t;
      m_fway = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : int'(m_lru[s]);
      m_valid[s][m_fway] = 0;
    end else if (req_valid && h && !(req_write && mem_busy)) begin
      if (req_write) begin
        m_data[s][w][req_addr[3:1]] = req_wdata;
        mem[req_addr[15:1]] = req_wdata;
      end
      m_lru[s] = (w == 0);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    fill_write_data = 1'b0;
    fill_write_tag = 1'b0;
    mem_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Holds one request, plays the bridge, and checks every cycle until accepted.
  task automatic access(input logic [15:0] a, input logic w,
                        input logic [15:0] d, input int busy_n,
                        input bit rnd);
    int n = 0;
    int bcnt = 0;
    bit done = 0;
    logic [67:0] e, o;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    while (!done) begin
      fill_write_data = 1'b0;
      fill_write_tag = 1'b0;
      fill_data = 16'($urandom);
      if (!m_fill) bcnt = 0;
      if (m_fill) begin
        if (bcnt < 8 && (!rnd || $urandom_range(0, 1) == 1)) begin
          fill_write_data = 1'b1;
          fill_data = mem[{m_ftag, m_fset, 3'(bcnt)}];
          bcnt++;
          if (bcnt == 8 && rnd && $urandom_range(0, 1) == 1)
            fill_write_tag = 1'b1;
        end else if (bcnt == 8) begin
          fill_write_tag = 1'b1;
        end
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        fill_write_data = 1'b1;
        fill_write_tag = 1'($urandom_range(0, 1));
      end
      mem_busy = (n < busy_n) || (rnd && $urandom_range(0, 2) == 0);
      #1;
      e = model_out();
      o = dut_out();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL access a=%h cyc=%0d got=%h want=%h", a, n, o, e);
      end
      done = e[67] && !e[50];
      tick();
      n++;
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL access_timeout a=%h got=stalled want=accepted", a);
        done = 1;
      end
    end
    req_valid = 1'b0;
    fill_write_data = 1'b0;
    fill_write_tag = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'h1234;
    #1;
    total++;
    if ({miss_detected, stall, mem_write_en, rdata} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {miss_detected, stall, mem_write_en, rdata});
    end
    tick();
    tick();
    rst = 1'b0;
    req_write = 1'b0;
    #1;
    total++;
    if ({hit, miss_detected} !== 2'b01) begin
      bad++;
      $display("FAIL reset_cold got=%b want=01", {hit, miss_detected});
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_cold_fill();
    do_reset();
    for (int i = 0; i < 8; i++) mem[15'h0918 + 15'(i)] = 16'hA000 + 16'(i);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h1234;
    #1;
    total++;
    if ({miss_detected, stall, miss_address} !== {2'b11, 16'h1230}) begin
      bad++;
      $display("FAIL cold_miss got=%h want=%h",
               {miss_detected, stall, miss_address}, {2'b11, 16'h1230});
    end
    tick();
    access(16'h1234, 1'b0, 16'h0, 0, 0);
    req_valid = 1'b1;
    req_addr = 16'h1234;
    #1;
    total++;
    if ({hit, rdata} !== {1'b1, 16'hA002}) begin
      bad++;
      $display("FAIL cold_hit got=%h want=%h", {hit, rdata}, {1'b1, 16'hA002});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_store_hit();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'h1236;
    req_wdata = 16'hBEEF;
    mem_busy = 1'b0;
    #1;
    total++;
    if ({mem_write_en, mem_addr, mem_wdata, stall} !==
        {1'b1, 16'h1236, 16'hBEEF, 1'b0}) begin
      bad++;
      $display("FAIL store_write got=%h want=%h",
               {mem_write_en, mem_addr, mem_wdata, stall},
               {1'b1, 16'h1236, 16'hBEEF, 1'b0});
    end
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (mem_write_en !== 1'b0) begin
      bad++;
      $display("FAIL store_pulse got=%b want=0", mem_write_en);
    end
    tick();
    req_valid = 1'b1;
    req_write = 1'b0;
    #1;
    total++;
    if ({hit, rdata} !== {1'b1, 16'hBEEF}) begin
      bad++;
      $display("FAIL store_readback got=%h want=%h", {hit, rdata}, {1'b1, 16'hBEEF});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_store_busy();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'h1236;
    req_wdata = 16'hCAFE;
    for (int c = 0; c < 3; c++) begin
      mem_busy = 1'b1;
      #1;
      total++;
      if ({stall, mem_write_en} !== 2'b10) begin
        bad++;
        $display("FAIL busy_hold cyc=%0d got=%b want=10", c, {stall, mem_write_en});
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    total++;
    if ({stall, mem_write_en, mem_wdata} !== {2'b01, 16'hCAFE}) begin
      bad++;
      $display("FAIL busy_release got=%h want=%h",
               {stall, mem_write_en, mem_wdata}, {2'b01, 16'hCAFE});
    end
    tick();
    req_write = 1'b0;
    #1;
    total++;
    if (rdata !== 16'hCAFE) begin
      bad++;
      $display("FAIL busy_readback got=%h want=cafe", rdata);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_eviction();
    do_reset();
    access(16'h0040, 1'b0, 16'h0, 0, 0);
    access(16'h0440, 1'b0, 16'h0, 0, 0);
    access(16'h0040, 1'b0, 16'h0, 0, 0);
    access(16'h0840, 1'b0, 16'h0, 0, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h0040;
    #1;
    total++;
    if (hit !== 1'b1) begin
      bad++;
      $display("FAIL evict_keep got=%b want=1", hit);
    end
    req_addr = 16'h0440;
    #1;
    total++;
    if ({hit, miss_detected} !== 2'b01) begin
      bad++;
      $display("FAIL evict_gone got=%b want=01", {hit, miss_detected});
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_during_fill();
    logic [15:0] a;
    a = 16'h2468;
    do_reset();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = a;
    tick();
    for (int i = 0; i < 4; i++) begin
      fill_write_data = 1'b1;
      fill_data = 16'hDEA0 + 16'(i);
      #1;
      total++;
      if ({hit, stall, miss_detected} !== 3'b011) begin
        bad++;
        $display("FAIL partial_fill cyc=%0d got=%b want=011", i,
                 {hit, stall, miss_detected});
      end
      tick();
    end
    fill_write_data = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({miss_detected, stall, mem_write_en, rdata} !== 19'h0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0",
               {miss_detected, stall, mem_write_en, rdata});
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({hit, miss_detected} !== 2'b01) begin
      bad++;
      $display("FAIL abort_remiss got=%b want=01", {hit, miss_detected});
    end
    tick();
    access(a, 1'b0, 16'h0, 0, 0);
    req_valid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      req_addr = {a[15:4], 3'(w), 1'b0};
      #1;
      total++;
      if ({hit, rdata} !== {1'b1, mem[req_addr[15:1]]}) begin
        bad++;
        $display("FAIL refill_word%0d got=%h want=%h", w, {hit, rdata},
                 {1'b1, mem[req_addr[15:1]]});
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] a;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      a = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           3'($urandom), 1'($urandom)};
      access(a, 1'($urandom), 16'($urandom), 0, 1);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    access(16'h0100, 1'b0, 16'h0, 0, 0);
    access(16'h0200, 1'b0, 16'h0, 0, 0);
    access(16'h0300, 1'b0, 16'h0, 0, 0);
    access(16'h0102, 1'b0, 16'h0, 0, 0);
    access(16'h0202, 1'b0, 16'h0, 0, 0);
    #1;
    total++;
    if ({miss_count, hit_count} !== {16'd3, 16'd5}) begin
      bad++;
      $display("FAIL perf_counts got=%0d/%0d want=3/5", miss_count, hit_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    #2;
    test_reset();
    test_cold_fill();
    test_store_hit();
    test_store_busy();
    test_eviction();
    test_reset_during_fill();
    test_random();
`ifdef DCACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

2-way set-associative, write-through, write-allocate data cache serving the pipeline MEM stage. It sits directly upstream of the cache/memory bridge. It raises a miss and a block-aligned miss address, then absorbs the bridge's word-by-word fill strobes into the victim way. It also issues write-through stores to main memory on the bridge's write port.

## Interface
- No parameters; geometry is fixed: 64 sets, 2 ways, 8 × 16-bit words per block.
- Address split: tag = addr[15:10], set = addr[9:4], word = addr[3:1], addr[0] ignored.
- `clk` in 1 — single clock; all state updates on posedge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — MEM-stage access present.
- `req_write` in 1 — 1 = store, 0 = load.
- `req_addr` in 16 — byte address of access.
- `req_wdata` in 16 — store data.
- `rdata` out 16 — load data. Equals the hit word; 16'h0000 when not hitting.
- `hit` out 1 — tag match in a valid way.
- `stall` out 1 — holds pipeline.
- `miss_detected` out 1 — to bridge `data_miss_detected`.
- `miss_address` out 16 — {req_addr[15:4], 4'h0}.
- `fill_write_data` in 1 — bridge data-array write strobe, one per fill word.
- `fill_write_tag` in 1 — bridge tag-array write strobe, block complete.
- `fill_data` in 16 — fill word.
- `mem_busy` in 1 — memory port occupied by another fill; stores must wait.
- `mem_write_en` out 1, `mem_addr` out 16, `mem_wdata` out 16 — write-through port.

## Operation
- Lookup is combinational on `req_addr`: compare the tag against both ways of the set. `hit` = `req_valid` & a way is valid & its tag matches.
- `miss_detected` = `req_valid` & ~`hit` & ~`rst`. It stays high throughout the fill, because the pipeline holds `req_addr` stable.
- `stall` = `req_valid` & (~`hit` | (`req_write` & `mem_busy`)).
- FSM has two states, IDLE and FILL.
  - IDLE → FILL on a miss. On entry, latch the fill set, the fill tag, and the victim way. The victim is way 0 if it is invalid, else way 1 if it is invalid, else the LRU way.
  - In FILL, each `fill_write_data` writes `fill_data` to data[set][victim][fill_cnt], then fill_cnt increments (3 bits, 7 wraps to 0).
  - In FILL, `fill_write_tag` writes the latched tag, sets valid, resets fill_cnt to 0, and returns to IDLE.
- If `fill_write_tag` coincides with the 8th `fill_write_data`, both take effect in the same edge.
- Fill strobes received in IDLE are ignored.
- Fill uses the latched set/tag/victim; changes to `req_addr` during FILL do not redirect the fill.
- Load hit (no stall): `rdata` = the word. LRU[set] points to the non-hit way.
- Store hit with ~`mem_busy`:
  - Write `req_wdata` into the hit word at the edge.
  - `mem_write_en`=1 for that cycle, with `mem_addr`=`req_addr` and `mem_wdata`=`req_wdata`.
  - Update LRU.
- Store hit with `mem_busy`: `stall`=1, no array or memory write, retry each cycle.
- Store miss: allocate via fill first; the store then completes as a store hit.

## Timing
- Reset values:
  - All valid bits 0, LRU 0, FSM IDLE, fill_cnt 0.
  - While `rst` is high: `miss_detected`, `stall`, `mem_write_en` = 0, `rdata` = 16'h0000.
  - Data and tag arrays are not reset.
- Hit latency is 0 cycles (same-cycle `rdata`).
- Miss penalty is set entirely by the bridge. `hit` rises the cycle after the `fill_write_tag` edge.
- Reset during FILL aborts the fill. After reset the partial block stays invalid, and the next access misses and restarts.
- `mem_write_en` is never high in FILL. It is a single-cycle pulse per accepted store.

## Configuration
- `DCACHE_PERF_CNT_EN` defined:
  - Adds outputs `hit_count` out 16 and `miss_count` out 16.
  - `hit_count` increments on each accepted hit.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- `dcache_pkg` holds the field widths, set/way/word counts, the state enum {IDLE, FILL}, and the tag/set/word extraction constants.
- One sub-module, `dcache_way_store`: one way's tag, valid and data arrays. It has combinational read, a synchronous word write, a synchronous tag/valid write, and async clear of valid. The controller instantiates two of them.

## Test plan
- Cold load to 16'h1234 → `miss_detected`=1, `miss_address`=16'h1230, `stall`=1. After 8 fills of 16'hA000..16'hA007 plus the tag strobe, the next cycle gives `hit`=1 and `rdata`=16'hA002 (word 2).
- Store 16'hBEEF to 16'h1236 after that fill, with `mem_busy`=0 → one-cycle `mem_write_en`, `mem_addr`=16'h1236. A subsequent load returns 16'hBEEF.
- Same store with `mem_busy`=1 for 3 cycles → `stall`=1 and no `mem_write_en` for those 3 cycles. The write happens in cycle 4.
- Fill 16'h0040 (way 0) and 16'h0440 (way 1), load 16'h0040, then miss on 16'h0840 → way 1 is evicted. 16'h0040 still hits and 16'h0440 misses.
- Assert `rst` after 4 fill words → FSM IDLE, load of the same address misses again, fill_cnt restarts at 0.
- With `DCACHE_PERF_CNT_EN` defined, run 3 misses and 5 hits → `miss_count`=3, `hit_count`=5.
